// File: rtl/dcache_bus_interface_if.sv
// -----------------------------------------------------------------------------
// dcache_bus_interface_if
// Bundles the cache-side and memory-bus-side signals of the data-cache bus
// interface block.
//   slave  : view of the bus interface block itself (takes cache requests and
//            memory responses, drives grants, fill data and bus commands).
//   master : view of the surrounding environment (cache + memory arbiter).
// Cache side : miss_request/miss_addr, wt_write/wt_addr/wt_data, err_clear,
//              cache_bus_grant, cache_datain, fill_valid, wb_full, wb_empty,
//              bus_error.
// Memory side: mem_bus_request, mem_bus_grant, mem_addr, mem_cmd,
//              mem_dataout, mem_datain, mem_ack.
// -----------------------------------------------------------------------------
interface dcache_bus_interface_if #(
  parameter int padd_size = 24,
  parameter int cmd_size  = 3,
  parameter int data_size = 32
);
  // cache side
  logic                 miss_request;
  logic [padd_size-1:0] miss_addr;
  logic                 wt_write;
  logic [padd_size-1:0] wt_addr;
  logic [data_size-1:0] wt_data;
  logic                 err_clear;
  logic                 cache_bus_grant;
  logic [data_size-1:0] cache_datain;
  logic                 fill_valid;
  logic                 wb_full;
  logic                 wb_empty;
  logic                 bus_error;
  // memory side
  logic                 mem_bus_request;
  logic                 mem_bus_grant;
  logic [padd_size-1:0] mem_addr;
  logic [cmd_size-1:0]  mem_cmd;
  logic [data_size-1:0] mem_dataout;
  logic [data_size-1:0] mem_datain;
  logic                 mem_ack;

  modport slave (
    input  miss_request, miss_addr, wt_write, wt_addr, wt_data, err_clear,
    input  mem_bus_grant, mem_datain, mem_ack,
    output cache_bus_grant, cache_datain, fill_valid, wb_full, wb_empty,
    output bus_error, mem_bus_request, mem_addr, mem_cmd, mem_dataout
  );

  modport master (
    output miss_request, miss_addr, wt_write, wt_addr, wt_data, err_clear,
    output mem_bus_grant, mem_datain, mem_ack,
    input  cache_bus_grant, cache_datain, fill_valid, wb_full, wb_empty,
    input  bus_error, mem_bus_request, mem_addr, mem_cmd, mem_dataout
  );
endinterface

// File: rtl/dcache_bus_interface.sv
// -----------------------------------------------------------------------------
// dcache_bus_interface
// Bridge between the LRU data cache and the system memory bus.
//  - Read misses are serviced with single-word fills returned on cache_datain
//    with a one-cycle fill_valid pulse.
//  - Write-through stores are posted into a small FIFO and drained to memory;
//    buffered writes always go out before a pending miss (read-after-write
//    ordering).
//  - Every bus transaction is watched by a timeout; expiry sets a sticky
//    bus_error that only err_clear removes.
// Ports:
//   clk0  : clock, all logic on the rising edge
//   reset : asynchronous active-low reset
//   bus   : dcache_bus_interface_if.slave (cache side + memory bus side)
// Bus commands: 000 idle, 001 read, 010 write.
// -----------------------------------------------------------------------------
module dcache_bus_interface #(
  parameter int padd_size      = 24,
  parameter int cmd_size       = 3,
  parameter int data_size      = 32,
  parameter int wbuf_depth     = 4,
  parameter int wbuf_ptr       = 2,
  parameter int timeout_cycles = 255
) (
  input logic                   clk0,
  input logic                   reset,
  dcache_bus_interface_if.slave bus
);

  localparam logic [cmd_size-1:0] cmd_idle  = cmd_size'(3'b000);
  localparam logic [cmd_size-1:0] cmd_read  = cmd_size'(3'b001);
  localparam logic [cmd_size-1:0] cmd_write = cmd_size'(3'b010);

  localparam int                  timer_w    = $clog2(timeout_cycles + 1);
  // Last count value seen without ack; one more silent cycle is the timeout.
  localparam logic [timer_w-1:0]  timer_last = timer_w'(timeout_cycles - 1);
  localparam logic [wbuf_ptr:0]   wbuf_full_cnt = (wbuf_ptr + 1)'(wbuf_depth);

  typedef enum logic [1:0] {
    st_idle,
    st_req,
    st_xfer,
    st_done
  } state_t;

  // ---------------------------------------------------------------------------
  // Write buffer
  // ---------------------------------------------------------------------------
  logic [padd_size-1:0] r_wb_addr [wbuf_depth];
  logic [data_size-1:0] r_wb_data [wbuf_depth];
  logic [wbuf_ptr-1:0]  r_wr_ptr;
  logic [wbuf_ptr-1:0]  r_rd_ptr;
  logic [wbuf_ptr:0]    r_count;
  logic                 w_wb_full;
  logic                 w_wb_empty;
  logic                 w_push;
  logic                 w_pop;

  assign w_wb_full  = (r_count == wbuf_full_cnt);
  assign w_wb_empty = (r_count == '0);
  // A push against a full buffer is dropped even if a pop frees a slot in the
  // same cycle; the upstream stage stalls on wb_full instead.
  assign w_push     = bus.wt_write && !w_wb_full;

  // NOTE: the storage array has no reset; validity is carried entirely by the
  // pointers and count, so clearing those is enough to discard stale entries.
  always_ff @(posedge clk0) begin
    if (w_push) begin
      r_wb_addr[r_wr_ptr] <= bus.wt_addr;
      r_wb_data[r_wr_ptr] <= bus.wt_data;
    end
  end

  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers are wbuf_ptr bits wide, so wrap modulo wbuf_depth is free.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction FSM with registered outputs
  // ---------------------------------------------------------------------------
  state_t               r_state,           w_state_nxt;
  logic                 r_is_read,         w_is_read_nxt;
  logic [padd_size-1:0] r_miss_addr,       w_miss_addr_nxt;
  logic [timer_w-1:0]   r_timer,           w_timer_nxt;
  logic                 r_mem_bus_request, w_mem_bus_request_nxt;
  logic [padd_size-1:0] r_mem_addr,        w_mem_addr_nxt;
  logic [cmd_size-1:0]  r_mem_cmd,         w_mem_cmd_nxt;
  logic [data_size-1:0] r_mem_dataout,     w_mem_dataout_nxt;
  logic                 r_cache_bus_grant, w_cache_bus_grant_nxt;
  logic [data_size-1:0] r_cache_datain,    w_cache_datain_nxt;
  logic                 r_fill_valid,      w_fill_valid_nxt;
  logic                 r_bus_error,       w_bus_error_nxt;
  logic                 w_timeout;

  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      r_state           <= st_idle;
      r_is_read         <= 1'b0;
      r_miss_addr       <= '0;
      r_timer           <= '0;
      r_mem_bus_request <= 1'b0;
      r_mem_addr        <= '0;
      r_mem_cmd         <= cmd_idle;
      r_mem_dataout     <= '0;
      r_cache_bus_grant <= 1'b0;
      r_cache_datain    <= '0;
      r_fill_valid      <= 1'b0;
      r_bus_error       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values that were present before the clock edge.
      r_state           <= w_state_nxt;
      r_is_read         <= w_is_read_nxt;
      r_miss_addr       <= w_miss_addr_nxt;
      r_timer           <= w_timer_nxt;
      r_mem_bus_request <= w_mem_bus_request_nxt;
      r_mem_addr        <= w_mem_addr_nxt;
      r_mem_cmd         <= w_mem_cmd_nxt;
      r_mem_dataout     <= w_mem_dataout_nxt;
      r_cache_bus_grant <= w_cache_bus_grant_nxt;
      r_cache_datain    <= w_cache_datain_nxt;
      r_fill_valid      <= w_fill_valid_nxt;
      r_bus_error       <= w_bus_error_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    w_state_nxt           = r_state;
    w_is_read_nxt         = r_is_read;
    w_miss_addr_nxt       = r_miss_addr;
    w_timer_nxt           = r_timer;
    w_mem_bus_request_nxt = r_mem_bus_request;
    w_mem_addr_nxt        = r_mem_addr;
    w_mem_cmd_nxt         = r_mem_cmd;
    w_mem_dataout_nxt     = r_mem_dataout;
    w_cache_bus_grant_nxt = r_cache_bus_grant;
    w_cache_datain_nxt    = r_cache_datain;
    w_fill_valid_nxt      = r_fill_valid;
    w_bus_error_nxt       = r_bus_error;
    w_pop                 = 1'b0;
    w_timeout             = 1'b0;

    if (bus.err_clear) w_bus_error_nxt = 1'b0;

    unique case (r_state)
      st_idle: begin
        // Buffered writes go first so a later miss never reads stale memory.
        if (!w_wb_empty) begin
          w_is_read_nxt         = 1'b0;
          w_mem_bus_request_nxt = 1'b1;
          w_state_nxt           = st_req;
        end else if (bus.miss_request) begin
          w_miss_addr_nxt       = bus.miss_addr;
          w_is_read_nxt         = 1'b1;
          w_mem_bus_request_nxt = 1'b1;
          w_state_nxt           = st_req;
        end
      end

      st_req: begin
        if (bus.mem_bus_grant) begin
          w_timer_nxt = '0;
          w_state_nxt = st_xfer;
          if (r_is_read) begin
            w_mem_addr_nxt        = r_miss_addr;
            w_mem_cmd_nxt         = cmd_read;
            w_cache_bus_grant_nxt = 1'b1;
          end else begin
            // The head entry cannot change until this write pops it.
            w_mem_addr_nxt    = r_wb_addr[r_rd_ptr];
            w_mem_dataout_nxt = r_wb_data[r_rd_ptr];
            w_mem_cmd_nxt     = cmd_write;
          end
        end
      end

      st_xfer: begin
        w_timeout = !bus.mem_ack && (r_timer == timer_last);
        if (bus.mem_ack || w_timeout) begin
          w_mem_cmd_nxt         = cmd_idle;
          w_mem_bus_request_nxt = 1'b0;
          // Set beats a simultaneous err_clear.
          if (w_timeout) w_bus_error_nxt = 1'b1;
          if (r_is_read) begin
            w_cache_datain_nxt = w_timeout ? '0 : bus.mem_datain;
            w_fill_valid_nxt   = 1'b1;
            w_state_nxt        = st_done;
          end else begin
            // A timed-out write is dropped rather than retried.
            w_pop       = 1'b1;
            w_state_nxt = st_idle;
          end
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      st_done: begin
        w_fill_valid_nxt      = 1'b0;
        w_cache_bus_grant_nxt = 1'b0;
        w_state_nxt           = st_idle;
      end

      default: w_state_nxt = st_idle;
    endcase
  end

  assign bus.cache_bus_grant = r_cache_bus_grant;
  assign bus.cache_datain    = r_cache_datain;
  assign bus.fill_valid      = r_fill_valid;
  assign bus.wb_full         = w_wb_full;
  assign bus.wb_empty        = w_wb_empty;
  assign bus.bus_error       = r_bus_error;
  assign bus.mem_bus_request = r_mem_bus_request;
  assign bus.mem_addr        = r_mem_addr;
  assign bus.mem_cmd         = r_mem_cmd;
  assign bus.mem_dataout     = r_mem_dataout;

endmodule

// File: tb/tb_dcache_bus_interface.sv
// -----------------------------------------------------------------------------
// tb_dcache_bus_interface
// Self-checking bench for dcache_bus_interface. Directed scenario tasks plus a
// randomized phase whose expectations come from a transaction-level model:
// a FIFO queue of accepted writes that must appear on the bus in order, and a
// single pending miss that is issued only once that queue is empty.
// -----------------------------------------------------------------------------
module tb_dcache_bus_interface;

  logic clk0 = 1'b0;
  logic reset;

  always #5 clk0 = ~clk0;

  dcache_bus_interface_if bus ();

  dcache_bus_interface dut (
    .clk0  (clk0),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] CMD_IDLE  = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [2:0] CMD_WRITE = 3'b010;

  // Expected output vector while/after reset: everything 0 except wb_empty.
  localparam logic [96:0] RESET_OUTS =
    {1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0, 3'h0, 32'h0};

  typedef struct packed {
    logic [23:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    bit          ok;
    bit          pre_grant_ok;
    bit          held_ok;
    logic [2:0]  cmd;
    logic [23:0] addr;
    logic [31:0] dout;
    logic        cbg;
    logic        fill;
    logic [31:0] fill_data;
    logic        req_after;
    logic        fill_after;
  } obs_t;

  function automatic logic [96:0] outs();
    return {bus.cache_bus_grant, bus.cache_datain, bus.fill_valid, bus.wb_full,
            bus.wb_empty, bus.bus_error, bus.mem_bus_request, bus.mem_addr,
            bus.mem_cmd, bus.mem_dataout};
  endfunction

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic init_inputs();
    bus.miss_request  = 1'b0;
    bus.miss_addr     = '0;
    bus.wt_write      = 1'b0;
    bus.wt_addr       = '0;
    bus.wt_data       = '0;
    bus.err_clear     = 1'b0;
    bus.mem_bus_grant = 1'b0;
    bus.mem_datain    = '0;
    bus.mem_ack       = 1'b0;
  endtask

  task automatic push_write(input logic [23:0] a, input logic [31:0] d);
    bus.wt_write = 1'b1;
    bus.wt_addr  = a;
    bus.wt_data  = d;
    tick();
    bus.wt_write = 1'b0;
  endtask

  // Plays the memory side for one transaction: waits for the request, delays
  // the grant, delays the ack, and records what the block showed on the way.
  task automatic service(input int gdly, input int adly, input logic [31:0] rdata,
                         output obs_t o);
    int n;
    o.ok = 1'b1; o.pre_grant_ok = 1'b1; o.held_ok = 1'b1;
    o.cmd = '0; o.addr = '0; o.dout = '0; o.cbg = 1'b0; o.fill = 1'b0;
    o.fill_data = '0; o.req_after = 1'b0; o.fill_after = 1'b0;
    n = 0;
    while (!bus.mem_bus_request && n < 100) begin
      tick();
      n++;
    end
    if (!bus.mem_bus_request) begin
      o.ok = 1'b0;
      return;
    end
    for (int i = 0; i < gdly; i++) begin
      if (bus.mem_cmd !== CMD_IDLE || bus.mem_bus_request !== 1'b1) o.pre_grant_ok = 1'b0;
      tick();
    end
    if (bus.mem_cmd !== CMD_IDLE || bus.mem_bus_request !== 1'b1) o.pre_grant_ok = 1'b0;
    bus.mem_bus_grant = 1'b1;
    tick();
    bus.mem_bus_grant = 1'b0;   // a grant drop during the transfer is legal
    o.cmd  = bus.mem_cmd;
    o.addr = bus.mem_addr;
    o.dout = bus.mem_dataout;
    o.cbg  = bus.cache_bus_grant;
    for (int i = 0; i < adly; i++) begin
      tick();
      if (bus.mem_cmd !== o.cmd || bus.mem_addr !== o.addr ||
          bus.mem_dataout !== o.dout || bus.fill_valid !== 1'b0) o.held_ok = 1'b0;
    end
    bus.mem_ack    = 1'b1;
    bus.mem_datain = rdata;
    tick();
    bus.mem_ack    = 1'b0;
    bus.mem_datain = '0;
    o.fill      = bus.fill_valid;
    o.fill_data = bus.cache_datain;
    o.req_after = bus.mem_bus_request;
    if (o.cmd == CMD_READ) bus.miss_request = 1'b0;
    tick();
    o.fill_after = bus.fill_valid;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    init_inputs();
    reset = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (outs() !== RESET_OUTS) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", outs(), RESET_OUTS);
    end
    reset = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (outs() !== RESET_OUTS) begin
      n_fail++;
      $display("FAIL idle_after_release: got %h expected %h", outs(), RESET_OUTS);
    end
  endtask

  task automatic test_miss_fill();
    int pulses;
    bus.miss_addr     = 24'h000123;
    bus.miss_request  = 1'b1;
    bus.mem_bus_grant = 1'b1;
    tick();
    n_checks++;
    if (bus.mem_bus_request !== 1'b1 || bus.mem_cmd !== CMD_IDLE) begin
      n_fail++;
      $display("FAIL miss_req_cycle1: got req=%b cmd=%b expected req=1 cmd=000",
               bus.mem_bus_request, bus.mem_cmd);
    end
    tick();
    n_checks++;
    if (bus.mem_cmd !== CMD_READ || bus.mem_addr !== 24'h000123 ||
        bus.cache_bus_grant !== 1'b1 || bus.fill_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_xfer_cycle2: got cmd=%b addr=%h grant=%b fill=%b expected 001 000123 1 0",
               bus.mem_cmd, bus.mem_addr, bus.cache_bus_grant, bus.fill_valid);
    end
    bus.mem_ack    = 1'b1;
    bus.mem_datain = 32'hDEADBEEF;
    tick();
    bus.mem_ack       = 1'b0;
    bus.mem_bus_grant = 1'b0;
    bus.miss_request  = 1'b0;
    n_checks++;
    if (bus.fill_valid !== 1'b1 || bus.cache_datain !== 32'hDEADBEEF ||
        bus.mem_cmd !== CMD_IDLE || bus.mem_bus_request !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_fill_cycle3: got fill=%b data=%h cmd=%b req=%b expected 1 deadbeef 000 0",
               bus.fill_valid, bus.cache_datain, bus.mem_cmd, bus.mem_bus_request);
    end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.fill_valid === 1'b1 || bus.cache_bus_grant === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL miss_single_pulse: got %0d extra fill/grant cycles expected 0", pulses);
    end
  endtask

  task automatic test_write_buffer();
    wr_t  w[4];
    obs_t o;
    int   stray;
    for (int i = 0; i < 4; i++) begin
      w[i].a = 24'hA00000 + 24'(i * 16);
      w[i].d = $urandom;
    end
    n_checks++;
    if (bus.wb_empty !== 1'b1 || bus.wb_full !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_initial: got empty=%b full=%b expected 1 0", bus.wb_empty, bus.wb_full);
    end
    for (int i = 0; i < 4; i++) push_write(w[i].a, w[i].d);
    n_checks++;
    if (bus.wb_full !== 1'b1 || bus.wb_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_full_after4: got full=%b empty=%b expected 1 0", bus.wb_full, bus.wb_empty);
    end
    push_write(24'hBBBBBB, 32'hBAD0BAD0);
    for (int i = 0; i < 4; i++) begin
      service($urandom_range(0, 2), $urandom_range(0, 3), 32'h0, o);
      n_checks++;
      if (!o.ok || o.cmd !== CMD_WRITE || o.addr !== w[i].a || o.dout !== w[i].d ||
          !o.held_ok || o.req_after !== 1'b0) begin
        n_fail++;
        $display("FAIL wb_drain_%0d: got ok=%0d cmd=%b addr=%h data=%h held=%0d req=%b expected 010 %h %h",
                 i, o.ok, o.cmd, o.addr, o.dout, o.held_ok, o.req_after, w[i].a, w[i].d);
      end
    end
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.mem_bus_request !== 1'b0 || bus.wb_empty !== 1'b1) stray++;
      tick();
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL wb_fifth_dropped: got %0d busy cycles expected 0", stray);
    end
  endtask

  task automatic test_write_before_read();
    obs_t o;
    push_write(24'h00C0DE, 32'h11112222);
    bus.miss_addr    = 24'h00F00D;
    bus.miss_request = 1'b1;
    service(1, 1, 32'h0, o);
    n_checks++;
    if (!o.ok || o.cmd !== CMD_WRITE || o.addr !== 24'h00C0DE || o.dout !== 32'h11112222) begin
      n_fail++;
      $display("FAIL raw_write_first: got ok=%0d cmd=%b addr=%h data=%h expected 010 00c0de 11112222",
               o.ok, o.cmd, o.addr, o.dout);
    end
    service(0, 2, 32'hCAFEF00D, o);
    n_checks++;
    if (!o.ok || o.cmd !== CMD_READ || o.addr !== 24'h00F00D || o.fill !== 1'b1 ||
        o.fill_data !== 32'hCAFEF00D || o.cbg !== 1'b1 || o.fill_after !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_read_second: got ok=%0d cmd=%b addr=%h fill=%b data=%h expected 001 00f00d 1 cafef00d",
               o.ok, o.cmd, o.addr, o.fill, o.fill_data);
    end
  endtask

  task automatic test_grant_delay();
    obs_t o;
    bus.miss_addr    = 24'h0ABCDE;
    bus.miss_request = 1'b1;
    service(10, 0, 32'h12345678, o);
    n_checks++;
    if (!o.ok || !o.pre_grant_ok || o.cmd !== CMD_READ || o.addr !== 24'h0ABCDE ||
        o.fill !== 1'b1 || o.fill_data !== 32'h12345678 || bus.bus_error !== 1'b0) begin
      n_fail++;
      $display("FAIL grant_delay: got ok=%0d pre=%0d cmd=%b fill=%b data=%h err=%b expected 1 1 001 1 12345678 0",
               o.ok, o.pre_grant_ok, o.cmd, o.fill, o.fill_data, bus.bus_error);
    end
  endtask

  task automatic test_timeout();
    int cnt;
    int n;
    bus.miss_addr    = 24'h000777;
    bus.miss_request = 1'b1;
    n = 0;
    while (!bus.mem_bus_request && n < 20) begin
      tick();
      n++;
    end
    bus.mem_bus_grant = 1'b1;
    tick();
    bus.mem_bus_grant = 1'b0;
    cnt = 0;
    while (bus.mem_cmd === CMD_READ && cnt < 400) begin
      cnt++;
      tick();
    end
    bus.miss_request = 1'b0;
    n_checks++;
    if (cnt != 255) begin
      n_fail++;
      $display("FAIL timeout_cycles: got %0d xfer cycles expected 255", cnt);
    end
    n_checks++;
    if (bus.bus_error !== 1'b1 || bus.fill_valid !== 1'b1 || bus.cache_datain !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout_fill: got err=%b fill=%b data=%h expected 1 1 00000000",
               bus.bus_error, bus.fill_valid, bus.cache_datain);
    end
    repeat (4) tick();
    n_checks++;
    if (bus.bus_error !== 1'b1) begin
      n_fail++;
      $display("FAIL error_sticky: got %b expected 1", bus.bus_error);
    end
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    n_checks++;
    if (bus.bus_error !== 1'b0) begin
      n_fail++;
      $display("FAIL error_clear: got %b expected 0", bus.bus_error);
    end
  endtask

  task automatic test_random();
    wr_t         wq[$];
    obs_t        o;
    bit          miss_pend;
    logic [23:0] maddr;
    logic [31:0] rdata;
    int          k;
    for (int it = 0; it < 25; it++) begin
      k = $urandom_range(0, 6);
      for (int j = 0; j < k; j++) begin
        wr_t e;
        e.a = 24'($urandom);
        e.d = $urandom;
        n_checks++;
        if (bus.wb_full !== (wq.size() == 4)) begin
          n_fail++;
          $display("FAIL rand_wb_full it%0d: got %b expected %0d", it, bus.wb_full, wq.size() == 4);
        end
        push_write(e.a, e.d);
        if (wq.size() < 4) wq.push_back(e);
      end
      miss_pend = ($urandom_range(0, 1) == 1);
      maddr     = 24'($urandom);
      if (miss_pend) begin
        bus.miss_addr    = maddr;
        bus.miss_request = 1'b1;
      end
      while (wq.size() > 0 || miss_pend) begin
        rdata = $urandom;
        service($urandom_range(0, 3), $urandom_range(0, 4), rdata, o);
        n_checks++;
        if (!o.ok) begin
          n_fail++;
          $display("FAIL rand_no_request it%0d: got no request expected one", it);
          return;
        end
        if (wq.size() > 0) begin
          if (o.cmd !== CMD_WRITE || o.addr !== wq[0].a || o.dout !== wq[0].d ||
              !o.held_ok || !o.pre_grant_ok || o.req_after !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_write it%0d: got cmd=%b addr=%h data=%h expected 010 %h %h",
                     it, o.cmd, o.addr, o.dout, wq[0].a, wq[0].d);
          end
          void'(wq.pop_front());
        end else begin
          if (o.cmd !== CMD_READ || o.addr !== maddr || o.fill !== 1'b1 ||
              o.fill_data !== rdata || o.fill_after !== 1'b0 || o.req_after !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_read it%0d: got cmd=%b addr=%h fill=%b data=%h expected 001 %h 1 %h",
                     it, o.cmd, o.addr, o.fill, o.fill_data, maddr, rdata);
          end
          miss_pend = 1'b0;
        end
      end
      n_checks++;
      if (bus.wb_empty !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_empty it%0d: got %b expected 1", it, bus.wb_empty);
      end
    end
  endtask

  task automatic test_reset_mid_xfer();
    int n;
    int stray;
    push_write(24'h0DEAD0, 32'hAAAA5555);
    push_write(24'h0DEAD4, 32'h5555AAAA);
    n = 0;
    while (!bus.mem_bus_request && n < 20) begin
      tick();
      n++;
    end
    bus.mem_bus_grant = 1'b1;
    tick();
    bus.mem_bus_grant = 1'b0;
    n_checks++;
    if (bus.mem_cmd !== CMD_WRITE || bus.mem_addr !== 24'h0DEAD0) begin
      n_fail++;
      $display("FAIL rst_pre_xfer: got cmd=%b addr=%h expected 010 0dead0", bus.mem_cmd, bus.mem_addr);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (outs() !== RESET_OUTS) begin
      n_fail++;
      $display("FAIL rst_mid_xfer_outputs: got %h expected %h", outs(), RESET_OUTS);
    end
    tick();
    reset = 1'b1;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.mem_bus_request !== 1'b0 || bus.mem_cmd !== CMD_IDLE || bus.wb_empty !== 1'b1) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL rst_no_stale_writes: got %0d busy cycles expected 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_write_buffer();
    test_write_before_read();
    test_grant_delay();
    test_timeout();
    test_random();
    test_reset_mid_xfer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
